msg_serializer: RTL and testbench
=================================

MSG_SERIALIZER -- requirements
Module: msg_serializer

Interface
REQ-001 Parameter DATA_BITS, default 8, character width; legal range 5..8.
REQ-002 Parameter NUM_CHARS, default 4, message buffer depth; ADDR_W = clog2(NUM_CHARS), minimum 1.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, stop-bit count; legal 1 or 2.
REQ-005 Parameter CLK_DIV, default 16, clocks per bit; legal ≥ 2.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 wr_en  input  1  buffer write strobe.
REQ-009 wr_addr  input  ADDR_W  buffer write address.
REQ-010 wr_data  input  DATA_BITS  character to store.
REQ-011 msg_len  input  ADDR_W+1  characters to send, sampled with start.
REQ-012 start  input  1  one-cycle request to transmit buffer[0..msg_len-1].
REQ-013 txd  output  1  serial line; idle high.
REQ-014 busy  output  1  high from the cycle after start is accepted until done.
REQ-015 done  output  1  one-cycle pulse when the message completes.

Function
REQ-016 A write with wr_en=1, busy=0 and wr_addr<NUM_CHARS shall store wr_data; writes while busy=1 or out of range shall be ignored.
REQ-017 start shall be accepted only when busy=0; start while busy=1 shall be ignored.
REQ-018 msg_len shall saturate to NUM_CHARS.
REQ-019 msg_len=0 on accepted start shall assert done in the next cycle, keep busy=0 and keep txd=1.
REQ-020 FSM states: IDLE, START, DATA, PAR, STOP, NEXT.
REQ-021 Transitions: IDLE→START on accepted start; START→DATA; DATA→PAR after DATA_BITS bits if PARITY≠0, else DATA→STOP; PAR→STOP; STOP→NEXT after STOP_BITS bits.
REQ-022 NEXT shall take one clock and go to START if characters remain, else to IDLE with done=1 for one cycle.
REQ-023 Each START, DATA, PAR and STOP bit shall hold txd for exactly CLK_DIV clocks.
REQ-024 txd shall be 0 in START, data LSB first in DATA, the parity bit in PAR, and 1 in STOP, NEXT and IDLE.
REQ-025 Even parity shall make the count of ones over data plus parity even; odd parity shall make it odd.
REQ-026 txd shall fall in the first clock after the start-accepting edge (latency 1), and txd shall be registered.
REQ-027 Character time shall be CLK_DIV*(1+DATA_BITS+(PARITY≠0)+STOP_BITS) clocks, plus 1 NEXT clock per character.
REQ-028 The bit counter and character index shall reset per character and per message; the index shall not wrap past msg_len-1.
REQ-029 Each character shall be latched from the buffer on entry to START and stay stable for the whole frame.

Reset
REQ-030 While rst_n=0: state=IDLE, txd=1, busy=0, done=0, all counters 0.
REQ-031 Reset asserted mid-frame shall abort at once, driving txd=1 without completing the frame or pulsing done.
REQ-032 Buffer contents shall be unaffected by reset and undefined after power-up until written.

Structure
REQ-033 The shared package shall hold the FSM state encoding and the PARITY mode constants (NONE=0, EVEN=1, ODD=2).
REQ-034 Bit timing shall be a sub-module baud_tick: a CLK_DIV counter with clear input, giving a one-cycle tick at the end of each bit period.
REQ-035 The buffer shall be a register array; no vendor RAM primitive.

Verification
REQ-036 Defaults, CLK_DIV=4: buffer[0]=0x41, msg_len=1, start → txd 0,1,0,0,0,0,0,1,0,1 for 4 clocks each; done at 41 clocks after the falling edge; busy low next cycle.
REQ-037 PARITY=1, buffer[0]=0x07 → parity bit 1; PARITY=2 → parity bit 0; frame 11 bits.
REQ-038 msg_len=4 with 0x41,0x42,0x43,0x44, STOP_BITS=2 → four frames back-to-back, one NEXT clock between them, a single done pulse; start pulses mid-message are ignored.
REQ-039 Write to address 1 while busy → buffer unchanged in the next message; msg_len=0 → done at cycle+1 and txd stays 1.
REQ-040 rst_n low during DATA bit 3 → txd=1, busy=0 asynchronously, no done; a fresh start after release sends the full frame.

Source files
------------

// File: rtl/msg_serializer_pkg.sv
// Shared FSM encoding, parity mode constants and parity helper for msg_serializer.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package msg_serializer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    NEXT  = 3'd5
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Parity bit that makes ones(data)+parity even (EVEN) or odd (ODD).
  // Narrow characters are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [7:0] d, input int mode);
    return (mode == PARITY_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/msg_serializer_baud_tick.sv
// Bit-period timer: counts CLK_DIV clocks and pulses tick in the last clock of each period.
// Latency: tick is high CLK_DIV-1 clocks after clear is released (count starts at zero).
// Backpressure: none; clear holds the counter at zero and suppresses tick.
module baud_tick #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(CLK_DIV - 1)) && !clear;

  // Free-running divider that restarts on clear and at the end of every bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/msg_serializer.sv
// UART-style serializer: sends buffer[0..msg_len-1] as start/data/parity/stop frames on txd.
// Latency: txd falls one clock after start is accepted; done pulses after the last NEXT clock.
// Backpressure: start and buffer writes are ignored while busy; no flow control on txd.
module msg_serializer
  import msg_serializer_pkg::*;
#(
  parameter  int DATA_BITS = 8,
  parameter  int NUM_CHARS = 4,
  parameter  int PARITY    = 0,
  parameter  int STOP_BITS = 1,
  parameter  int CLK_DIV   = 16,
  localparam int ADDR_W    = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_W:0]      msg_len,
  input  logic                 start,
  output logic                 txd,
  output logic                 busy,
  output logic                 done
);

  // Bit counter covers both data bit position (< DATA_BITS) and stop bit count.
  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(NUM_CHARS);

  logic [DATA_BITS-1:0] mem [NUM_CHARS];

  state_t               state;
  logic [DATA_BITS-1:0] char_q;
  logic [CNT_W-1:0]     bit_cnt;
  logic [ADDR_W-1:0]    idx;
  logic [ADDR_W:0]      len_q;

  logic                 tick;
  logic                 clear;
  logic [ADDR_W:0]      len_sat;
  logic [CNT_W-1:0]     bit_nxt;
  logic [ADDR_W-1:0]    idx_nxt;
  logic                 last_char;
  logic                 par;

  assign len_sat   = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
  assign bit_nxt   = bit_cnt + CNT_W'(1);
  assign idx_nxt   = idx + ADDR_W'(1);
  assign last_char = ({1'b0, idx} == (len_q - (ADDR_W + 1)'(1)));
  assign par       = parity_bit(8'(char_q), PARITY);
  // The bit timer only runs while a bit is on the line.
  assign clear     = (state == IDLE) || (state == NEXT);

  baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .tick  (tick)
  );

  // Message buffer: plain register array, deliberately not reset, frozen while a message is in flight.
  always_ff @(posedge clk) begin
    if (wr_en && !busy && ({1'b0, wr_addr} < MAX_LEN)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Frame sequencer: registered txd/busy/done, one state per frame field plus a one-clock NEXT gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      txd     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_cnt <= '0;
      idx     <= '0;
      len_q   <= '0;
      char_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          txd  <= 1'b1;
          busy <= 1'b0;
          // busy is still high during the done cycle, so a start there is ignored.
          if (start && !busy) begin
            if (len_sat == '0) begin
              done <= 1'b1;
            end else begin
              state   <= START;
              txd     <= 1'b0;
              busy    <= 1'b1;
              idx     <= '0;
              len_q   <= len_sat;
              bit_cnt <= '0;
              char_q  <= mem[0];
            end
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            txd     <= char_q[0];
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (PARITY != PARITY_NONE) begin
                state <= PAR;
                txd   <= par;
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_nxt;
              txd     <= char_q[bit_nxt];
            end
          end
        end
        PAR: begin
          if (tick) begin
            state   <= STOP;
            txd     <= 1'b1;
            bit_cnt <= '0;
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_cnt == CNT_W'(STOP_BITS - 1)) begin
              state   <= NEXT;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_nxt;
            end
          end
        end
        NEXT: begin
          if (last_char) begin
            state <= IDLE;
            done  <= 1'b1;
            idx   <= '0;
          end else begin
            state  <= START;
            txd    <= 1'b0;
            idx    <= idx_nxt;
            char_q <= mem[idx_nxt];
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_serializer.sv
// Self-checking bench: three serializer variants share stimulus; per-cycle expected txd/busy/done
// are queued when a start is driven and compared on every falling clock edge.
// An empty queue means the variant must be idle (txd=1, busy=0, done=0).
module tb_msg_serializer;

  localparam int CD = 4;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] msg_len;
  logic       start;

  logic txd_a, busy_a, done_a;
  logic txd_b, busy_b, done_b;
  logic txd_c, busy_c, done_c;

  msg_serializer #(.CLK_DIV(CD)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .start(start), .txd(txd_a), .busy(busy_a), .done(done_a)
  );

  msg_serializer #(.PARITY(1), .CLK_DIV(CD)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .start(start), .txd(txd_b), .busy(busy_b), .done(done_b)
  );

  msg_serializer #(.PARITY(2), .STOP_BITS(2), .CLK_DIV(CD)) u_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .start(start), .txd(txd_c), .busy(busy_c), .done(done_c)
  );

  typedef struct packed {
    logic txd;
    logic busy;
    logic done;
  } obs_t;

  localparam obs_t OBS_IDLE = 3'b100;

  typedef struct {
    logic [7:0] d;
    logic       par_even;
    logic       par_odd;
  } vec_t;

  obs_t       qa[$];
  obs_t       qb[$];
  obs_t       qc[$];
  int         checks = 0;
  int         errors = 0;
  bit         chk_en = 0;
  logic [7:0] mem [4];
  vec_t       tbl [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: txd/busy/done got %b required %b", name, $time, act, exp);
    end
  endtask

  // Per-cycle scoreboard pop and compare, away from the active edge.
  always @(negedge clk) begin
    obs_t ea, eb, ec;
    if (chk_en) begin
      ea = (qa.size() > 0) ? qa.pop_front() : OBS_IDLE;
      eb = (qb.size() > 0) ? qb.pop_front() : OBS_IDLE;
      ec = (qc.size() > 0) ? qc.pop_front() : OBS_IDLE;
      cmp("cycle_a", {txd_a, busy_a, done_a}, ea);
      cmp("cycle_b", {txd_b, busy_b, done_b}, eb);
      cmp("cycle_c", {txd_c, busy_c, done_c}, ec);
    end
  end

  task automatic push_obs(input int k, input obs_t o);
    case (k)
      0:       qa.push_back(o);
      1:       qb.push_back(o);
      default: qc.push_back(o);
    endcase
  endtask

  // Expected waveform of one frame, starting with the clock after the accepting edge.
  task automatic push_char(input int k, input logic [7:0] d, input logic par,
                           input int pmode, input int nstop, input bit last);
    repeat (CD) push_obs(k, 3'b010);
    for (int i = 0; i < 8; i++) repeat (CD) push_obs(k, {d[i], 2'b10});
    if (pmode != 0) repeat (CD) push_obs(k, {par, 2'b10});
    repeat (CD * nstop) push_obs(k, 3'b110);
    push_obs(k, 3'b110);
    if (last) push_obs(k, 3'b111);
  endtask

  function automatic logic mpar(input logic [7:0] d, input int pmode);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (pmode == 2) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic push_msg(input int n);
    for (int c = 0; c < n; c++) begin
      push_char(0, mem[c], 1'b0, 0, 1, c == n - 1);
      push_char(1, mem[c], mpar(mem[c], 1), 1, 1, c == n - 1);
      push_char(2, mem[c], mpar(mem[c], 2), 2, 2, c == n - 1);
    end
  endtask

  task automatic do_start(input int len);
    @(posedge clk);
    #1 msg_len = 3'(len);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [7:0] d);
    @(posedge clk);
    #1 wr_en = 1'b1;
    wr_addr = 2'(a);
    wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((qa.size() + qb.size() + qc.size()) > 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if ((qa.size() + qb.size() + qc.size()) > 0) begin
      errors++;
      $display("FAIL %s: scoreboard not drained, %0d entries left, required 0", name,
               qa.size() + qb.size() + qc.size());
      qa.delete(); qb.delete(); qc.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8'h41, 1'b0, 1'b1};
    tbl[1] = '{8'h07, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 1'b0, 1'b1};
    tbl[3] = '{8'hFF, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 1'b1, 1'b0};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_len = '0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_a", {txd_a, busy_a, done_a}, OBS_IDLE);
    cmp("reset_b", {txd_b, busy_b, done_b}, OBS_IDLE);
    cmp("reset_c", {txd_c, busy_c, done_c}, OBS_IDLE);
    chk_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single-character frames with tabulated parity bits.
    for (int v = 0; v < 5; v++) begin
      do_write(0, tbl[v].d);
      mem[0] = tbl[v].d;
      do_start(1);
      push_char(0, tbl[v].d, 1'b0, 0, 1, 1'b1);
      push_char(1, tbl[v].d, tbl[v].par_even, 1, 1, 1'b1);
      push_char(2, tbl[v].d, tbl[v].par_odd, 2, 2, 1'b1);
      wait_idle("table_frame");
    end

    // Four back-to-back frames; mid-message start and write must be ignored.
    for (int i = 0; i < 4; i++) begin
      do_write(i, 8'h41 + 8'(i));
      mem[i] = 8'h41 + 8'(i);
    end
    do_start(4);
    push_msg(4);
    repeat (20) @(posedge clk);
    #1 msg_len = 3'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    do_write(1, 8'h99);
    wait_idle("four_chars");
    do_start(2);
    push_msg(2);
    wait_idle("buffer_kept");

    // Zero-length message: done next cycle, busy low, line idle.
    do_start(0);
    push_obs(0, 3'b101);
    push_obs(1, 3'b101);
    push_obs(2, 3'b101);
    wait_idle("zero_len");

    // Oversized length saturates to the buffer depth.
    do_start(7);
    push_msg(4);
    wait_idle("len_saturate");

    // Reset during data bit 3 aborts immediately without done.
    do_start(1);
    push_msg(1);
    repeat (17) @(posedge clk);
    #2 rst_n = 1'b0;
    qa.delete(); qb.delete(); qc.delete();
    #1;
    cmp("abort_a", {txd_a, busy_a, done_a}, OBS_IDLE);
    cmp("abort_b", {txd_b, busy_b, done_b}, OBS_IDLE);
    cmp("abort_c", {txd_c, busy_c, done_c}, OBS_IDLE);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    do_start(1);
    push_msg(1);
    wait_idle("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
